crc_frame_ctrl: RTL and testbench

Frame-level controller for the serial 8-bit CRC engine. It buffers a byte frame from an upstream valid/ready source and re-seeds the engine through its async reset. It then drives the engine's data and active inputs with every frame bit back-to-back, with no gaps. Finally it collects the 8 serial CRC bits and presents them as one byte with a valid/ready handshake. It sits between the packet source and the CRC engine; the engine is instantiated beside it, not inside it.

---
 rtl/crc_frame_ctrl_pkg.sv | 28 ++
 rtl/crc_frame_ctrl_if.sv | 36 +++
 rtl/crc_frame_buf.sv | 66 ++++++
 rtl/crc_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_ctrl_pkg.sv
// Shared types and constants for the CRC frame controller and its frame buffer.
package crc_frame_ctrl_pkg;

  localparam int unsigned CRC_W  = 8;
  localparam int unsigned BYTE_W = 8;

  // Frame bits go to the engine LSB-first; the serial CRC arrives MSB-first.
  localparam bit DATA_LSB_FIRST = 1'b1;
  localparam bit CRC_MSB_FIRST  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSeed,
    StShift,
    StDrain,
    StDone
  } state_e;

  function automatic logic [CRC_W-1:0] crc_collect(input logic [CRC_W-1:0] acc,
                                                   input logic             b);
    if (CRC_MSB_FIRST) begin
      return {acc[CRC_W-2:0], b};
    end
    return {b, acc[CRC_W-1:1]};
  endfunction

endpackage

// File: rtl/crc_frame_ctrl_if.sv
// Byte-in, engine-side and result handshake signals of the CRC frame controller.
interface crc_frame_ctrl_if
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  logic              crc_rst_n;
  logic              crc_active;
  logic              crc_data;
  logic              crc_bit;
  logic              crc_valid;

  logic [CRC_W-1:0]  out_crc;
  logic [LEN_W-1:0]  out_len;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_data, in_valid, in_last, crc_bit, crc_valid, out_ready,
    output in_ready, crc_rst_n, crc_active, crc_data, out_crc, out_len, out_err, out_valid
  );

  modport slave (
    output in_data, in_valid, in_last, crc_bit, crc_valid, out_ready,
    input  in_ready, crc_rst_n, crc_active, crc_data, out_crc, out_len, out_err, out_valid
  );

endinterface

// File: rtl/crc_frame_buf.sv
// DEPTH x 8 frame buffer: byte writes at wr_ptr, bit-serial reads via byte/bit counters.
module crc_frame_buf
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [BYTE_W-1:0]          wr_data,
  input  logic                       rd_adv,
  output logic                       rd_data,
  output logic                       rd_done,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     len
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LEN_W = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_byte_q;
  logic [2:0]        rd_bit_q;
  logic [2:0]        bit_idx;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      len_q     <= '0;
      rd_byte_q <= '0;
      rd_bit_q  <= '0;
    end else if (clr) begin
      wr_ptr_q  <= '0;
      len_q     <= '0;
      rd_byte_q <= '0;
      rd_bit_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        len_q    <= len_q + 1'b1;
      end
      if (rd_adv) begin
        rd_bit_q <= rd_bit_q + 1'b1;
        if (rd_bit_q == 3'd7) begin
          rd_byte_q <= rd_byte_q + 1'b1;
        end
      end
    end
  end

  assign bit_idx = DATA_LSB_FIRST ? rd_bit_q : (3'd7 - rd_bit_q);
  // Once rd_byte reaches len every bit has been issued; the wrapped index is never used.
  assign rd_data = mem[rd_byte_q[AW-1:0]][bit_idx];
  assign rd_done = (rd_byte_q == len_q);
  assign full    = (len_q == LEN_W'(DEPTH));
  assign len     = len_q;

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame controller: buffers a byte frame, seeds and feeds the serial CRC engine,
// collects the serial CRC and presents it with a valid/ready handshake.
module crc_frame_ctrl
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DRAIN_TO = 12
) (
  input logic              CLK,
  input logic              RST,
  crc_frame_ctrl_if.master bus
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(DRAIN_TO + 1);

  state_e           st_q, st_d;
  logic             wr_en, rd_adv, clr;
  logic             rd_data, rd_done, full;
  logic [LEN_W-1:0] len;
  logic             hs, done_err;

  logic             ovf_q, ovf_d;
  logic [2:0]       smp_q, smp_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CRC_W-1:0] col_q, col_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q;
  logic             crc_rst_n_q, crc_active_q, crc_data_q;

  crc_frame_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (bus.in_data),
    .rd_adv  (rd_adv),
    .rd_data (rd_data),
    .rd_done (rd_done),
    .full    (full),
    .len     (len)
  );

  assign bus.in_ready = (st_q == StLoad);
  assign hs           = bus.in_valid & bus.in_ready;

  always_comb begin
    st_d      = st_q;
    wr_en     = 1'b0;
    rd_adv    = 1'b0;
    clr       = 1'b0;
    done_err  = 1'b0;
    ovf_d     = ovf_q;
    smp_d     = smp_q;
    tmo_d     = '0;
    col_d     = col_q;
    out_len_d = out_len_q;
    out_err_d = out_err_q;

    unique case (st_q)
      StIdle: st_d = StLoad;
      StLoad: begin
        if (hs) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
          if (bus.in_last) begin
            // An overflowed frame is never sent to the engine.
            if (full || ovf_q) begin
              st_d     = StDone;
              done_err = 1'b1;
            end else begin
              st_d = StSeed;
            end
          end
        end
      end
      StSeed: begin
        rd_adv = 1'b1;
        st_d   = StShift;
      end
      StShift: begin
        if (rd_done) begin
          st_d = StDrain;
        end else begin
          rd_adv = 1'b1;
        end
      end
      StDrain: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.crc_valid) begin
          col_d = crc_collect(col_q, bus.crc_bit);
          smp_d = smp_q + 1'b1;
        end
        if (bus.crc_valid && (smp_q == 3'd7)) begin
          st_d = StDone;
        end else if (tmo_q == TMO_W'(DRAIN_TO - 1)) begin
          st_d     = StDone;
          done_err = 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          st_d      = StIdle;
          clr       = 1'b1;
          ovf_d     = 1'b0;
          smp_d     = '0;
          col_d     = '0;
          out_len_d = '0;
          out_err_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase

    if ((st_q != StDone) && (st_d == StDone)) begin
      out_len_d = len;
      out_err_d = done_err;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q         <= StIdle;
      ovf_q        <= 1'b0;
      smp_q        <= '0;
      tmo_q        <= '0;
      col_q        <= '0;
      out_len_q    <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      crc_rst_n_q  <= 1'b1;
      crc_active_q <= 1'b0;
      crc_data_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      ovf_q        <= ovf_d;
      smp_q        <= smp_d;
      tmo_q        <= tmo_d;
      col_q        <= col_d;
      out_len_q    <= out_len_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= (st_d == StDone);
      crc_rst_n_q  <= (st_d != StSeed);
      crc_active_q <= (st_d == StShift);
      // rd_adv is high exactly on the edges that enter or stay in SHIFT.
      crc_data_q   <= rd_adv & rd_data;
    end
  end

  assign bus.crc_rst_n  = crc_rst_n_q;
  assign bus.crc_active = crc_active_q;
  assign bus.crc_data   = crc_data_q;
  assign bus.out_crc    = col_q;
  assign bus.out_len    = out_len_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl with a behavioural serial CRC-8 engine beside it.
module tb_crc_frame_ctrl;
  import crc_frame_ctrl_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned DRAIN_TO = 12;
  localparam int MODE_REAL   = 0;
  localparam int MODE_STUB   = 1;
  localparam int MODE_SILENT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  crc_frame_ctrl_if #(.DEPTH(DEPTH)) bus ();

  crc_frame_ctrl #(
    .DEPTH    (DEPTH),
    .DRAIN_TO (DRAIN_TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Engine: CRC-8 poly 0x07, seed 0xFF, one data bit per ACTIVE cycle; after ACTIVE
  // falls it streams the CRC MSB-first for 8 cycles (or a fixed stub value, or nothing).
  int         eng_mode = MODE_REAL;
  logic [7:0] stub_val = 8'hB2;
  logic       eng_rst_n;
  logic [7:0] e_crc, e_sr;
  int         e_cnt;
  logic       e_seen;
  assign eng_rst_n = RST & bus.crc_rst_n;

  always @(posedge CLK or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      e_crc <= 8'hFF; e_sr <= 8'h00; e_cnt <= 0; e_seen <= 1'b0;
      bus.crc_valid <= 1'b0; bus.crc_bit <= 1'b0;
    end else if (bus.crc_active) begin
      e_crc  <= {e_crc[6:0], 1'b0} ^ ((e_crc[7] ^ bus.crc_data) ? 8'h07 : 8'h00);
      e_seen <= 1'b1;
      bus.crc_valid <= 1'b0;
    end else if (e_seen && eng_mode != MODE_SILENT) begin
      e_seen        <= 1'b0;
      bus.crc_valid <= 1'b1;
      bus.crc_bit   <= (eng_mode == MODE_STUB) ? stub_val[7] : e_crc[7];
      e_sr          <= (eng_mode == MODE_STUB) ? {stub_val[6:0], 1'b0} : {e_crc[6:0], 1'b0};
      e_cnt         <= 7;
    end else if (e_cnt > 0) begin
      bus.crc_valid <= 1'b1;
      bus.crc_bit   <= e_sr[7];
      e_sr          <= {e_sr[6:0], 1'b0};
      e_cnt         <= e_cnt - 1;
    end else begin
      bus.crc_valid <= 1'b0;
    end
  end

  // Running totals of engine-side activity, sampled mid-cycle.
  int   act_tot = 0, runs_tot = 0, seed_tot = 0;
  logic prev_act = 1'b0;
  logic mon_bits[$];
  always @(negedge CLK) begin
    if (bus.crc_active) begin
      act_tot <= act_tot + 1;
      mon_bits.push_back(bus.crc_data);
      if (!prev_act) runs_tot <= runs_tot + 1;
    end
    if (!bus.crc_rst_n) seed_tot <= seed_tot + 1;
    prev_act <= bus.crc_active;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] golden_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[7] ^ b[i][j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic void ref_model(input logic [7:0] b[$], input int mode,
                                    output logic [7:0] crc, output int len, output bit err);
    bit ovf;
    ovf = b.size() > int'(DEPTH);
    len = ovf ? int'(DEPTH) : b.size();
    err = ovf || (mode == MODE_SILENT);
    crc = (mode == MODE_STUB) ? stub_val : golden_crc(b);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " in_ready"},   bus.in_ready,   0);
    check({tag, " crc_rst_n"},  bus.crc_rst_n,  1);
    check({tag, " crc_active"}, bus.crc_active, 0);
    check({tag, " crc_data"},   bus.crc_data,   0);
    check({tag, " out_valid"},  bus.out_valid,  0);
    check({tag, " out_crc"},    bus.out_crc,    0);
    check({tag, " out_len"},    bus.out_len,    0);
    check({tag, " out_err"},    bus.out_err,    0);
  endtask

  task automatic send_bytes(input string tag, input logic [7:0] b[$], input int gap,
                            output bit ok);
    int budget;
    ok = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (gap) begin @(posedge CLK); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      bus.in_last  = (i == b.size() - 1);
      budget = 40;
      while (!bus.in_ready && budget > 0) begin @(posedge CLK); #1; budget--; end
      if (!bus.in_ready) begin
        check({tag, " in_ready timeout"}, 0, 1);
        ok = 1'b0;
        break;
      end
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$], input int mode,
                           input int gap, input int hold, input logic [7:0] exp_crc,
                           input int exp_len, input bit exp_err);
    int n, a0, r0, s0, q0, t0, budget, lat, exp_lat, mism;
    bit ovf, ok, stable;
    logic [7:0] snap_crc;
    n   = b.size();
    ovf = n > int'(DEPTH);
    a0 = act_tot; r0 = runs_tot; s0 = seed_tot; q0 = mon_bits.size();
    eng_mode = mode;
    send_bytes(tag, b, gap, ok);
    if (!ok) return;
    t0 = cyc;
    budget = 8 * n + 60;
    while (!bus.out_valid && budget > 0) begin @(posedge CLK); #1; budget--; end
    if (!bus.out_valid) begin
      check({tag, " out_valid timeout"}, 0, 1);
      return;
    end
    lat     = cyc - t0;
    exp_lat = ovf ? 0 : (mode == MODE_SILENT) ? 1 + 8 * n + int'(DRAIN_TO) : 8 * n + 10;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " out_len"}, bus.out_len, exp_len);
    check({tag, " out_err"}, bus.out_err, exp_err);
    if (!exp_err) check({tag, " out_crc"}, bus.out_crc, exp_crc);
    check({tag, " active cycles"}, act_tot - a0, ovf ? 0 : 8 * n);
    check({tag, " active runs"}, runs_tot - r0, ovf ? 0 : 1);
    check({tag, " seed cycles"}, seed_tot - s0, ovf ? 0 : 1);
    if (!ovf) begin
      mism = 0;
      for (int k = 0; k < 8 * n; k++) begin
        if (q0 + k >= mon_bits.size()) mism++;
        else if (mon_bits[q0 + k] !== b[k / 8][k % 8]) mism++;
      end
      check({tag, " crc_data bits"}, mism, 0);
    end
    snap_crc = bus.out_crc;
    bus.out_ready = 1'b0;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      if (!bus.out_valid || bus.out_crc !== snap_crc || bus.out_len !== exp_len[4:0] ||
          bus.out_err !== exp_err || bus.in_ready) stable = 1'b0;
    end
    if (hold > 0) check({tag, " hold stable"}, stable, 1);
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid after accept"}, bus.out_valid, 0);
    check({tag, " idle bubble"}, bus.in_ready, 0);
    @(posedge CLK); #1;
    check({tag, " load after idle"}, bus.in_ready, 1);
  endtask

  typedef struct {
    logic [19:0][7:0] data;
    int               n;
    int               mode;
    int               gap;
    int               hold;
    logic [7:0]       exp_crc;
    int               exp_len;
    bit               exp_err;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] vec_golden(input vec_t v);
    logic [7:0] q[$];
    for (int i = 0; i < v.n; i++) q.push_back(v.data[i]);
    return golden_crc(q);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] m_crc;
    int         m_len, n, mode;
    bit         m_err, ok;

    foreach (vecs[i]) begin
      vecs[i].data = '0; vecs[i].gap = 0; vecs[i].hold = 0; vecs[i].exp_crc = 8'h00;
    end
    vecs[0].n = 1;  vecs[0].mode = MODE_STUB; vecs[0].data[0] = 8'h55;
    vecs[0].exp_crc = 8'hB2; vecs[0].exp_len = 1; vecs[0].exp_err = 1'b0;
    vecs[1].n = 3;  vecs[1].mode = MODE_REAL; vecs[1].gap = 3;
    vecs[1].data[0] = 8'h01; vecs[1].data[1] = 8'h80; vecs[1].data[2] = 8'hFF;
    vecs[1].exp_len = 3; vecs[1].exp_err = 1'b0;
    vecs[2].n = 17; vecs[2].mode = MODE_REAL;
    for (int i = 0; i < 17; i++) vecs[2].data[i] = 8'(i * 7 + 3);
    vecs[2].exp_len = 16; vecs[2].exp_err = 1'b1;
    vecs[3].n = 2;  vecs[3].mode = MODE_SILENT; vecs[3].data[0] = 8'hA5;
    vecs[3].data[1] = 8'h3C; vecs[3].exp_len = 2; vecs[3].exp_err = 1'b1;
    vecs[4].n = 4;  vecs[4].mode = MODE_REAL; vecs[4].hold = 5;
    vecs[4].data[0] = 8'h12; vecs[4].data[1] = 8'h34; vecs[4].data[2] = 8'h56;
    vecs[4].data[3] = 8'h78; vecs[4].exp_len = 4; vecs[4].exp_err = 1'b0;
    vecs[5].n = 16; vecs[5].mode = MODE_REAL; vecs[5].gap = 1; vecs[5].hold = 2;
    for (int i = 0; i < 16; i++) vecs[5].data[i] = 8'hF0 ^ 8'(i);
    vecs[5].exp_len = 16; vecs[5].exp_err = 1'b0;
    vecs[1].exp_crc = vec_golden(vecs[1]);
    vecs[4].exp_crc = vec_golden(vecs[4]);
    vecs[5].exp_crc = vec_golden(vecs[5]);

    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #12;
    check_reset("reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    check(" first idle", bus.in_ready, 0);
    @(posedge CLK); #1;
    check("first load", bus.in_ready, 1);

    foreach (vecs[v]) begin
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].data[i]);
      run_frame($sformatf("vec%0d", v), q, vecs[v].mode, vecs[v].gap, vecs[v].hold,
                vecs[v].exp_crc, vecs[v].exp_len, vecs[v].exp_err);
    end

    // Reset mid-SHIFT, then a clean frame must still produce the right CRC.
    q.delete();
    q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
    eng_mode = MODE_REAL;
    send_bytes("midrst", q, 0, ok);
    repeat (10) begin @(posedge CLK); #1; end
    check("midrst in shift", bus.crc_active, 1);
    RST = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge CLK); #1;
    RST = 1'b1;
    q.delete();
    q.push_back(8'h9C); q.push_back(8'h00); q.push_back(8'h41);
    ref_model(q, MODE_REAL, m_crc, m_len, m_err);
    run_frame("post reset", q, MODE_REAL, 0, 0, m_crc, m_len, m_err);

    for (int f = 0; f < 20; f++) begin
      q.delete();
      n    = ($urandom_range(5, 0) == 0) ? $urandom_range(19, 17) : $urandom_range(16, 1);
      mode = ($urandom_range(7, 0) == 0) ? MODE_SILENT : MODE_REAL;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      ref_model(q, mode, m_crc, m_len, m_err);
      run_frame($sformatf("rand%0d", f), q, mode, $urandom_range(2, 0),
                $urandom_range(3, 0), m_crc, m_len, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
